// File: rtl/frame_hit_resolver.sv
// Turns per-frame collision flags into game state: NPC life/explosions, rocket retire
// pulses, ship life/respawn FSMs, score, wave and game over. TWO_PLAYER_EN builds ship 2.
module frame_hit_ship #(
    parameter int START_LIVES    = 3,
    parameter int EXPLODE_FRAMES = 8,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic       VGA_CLK,
    input  logic       Reset,
    input  logic       tick,
    input  logic       hit,
    output logic [1:0] state,
    output logic [2:0] lives
);
    localparam logic [1:0] ST_ALIVE   = 2'd0;
    localparam logic [1:0] ST_EXPLODE = 2'd1;
    localparam logic [1:0] ST_RESPAWN = 2'd2;
    localparam logic [1:0] ST_DEAD    = 2'd3;

    logic [5:0] timer;

    always_ff @(posedge VGA_CLK) begin
        if (Reset) begin
            state <= ST_ALIVE;
            lives <= 3'(START_LIVES);
            timer <= '0;
        end else if (tick) begin
            case (state)
                ST_ALIVE: begin
                    if (hit) begin
                        state <= ST_EXPLODE;
                        timer <= 6'(EXPLODE_FRAMES);
                        lives <= lives - 3'd1;
                    end
                end
                ST_EXPLODE: begin
                    // The last explosion frame decides between respawn and death.
                    if (timer == 6'd1) begin
                        if (lives == 3'd0) begin
                            state <= ST_DEAD;
                            timer <= '0;
                        end else begin
                            state <= ST_RESPAWN;
                            timer <= 6'(RESPAWN_FRAMES);
                        end
                    end else begin
                        timer <= timer - 6'd1;
                    end
                end
                ST_RESPAWN: begin
                    if (timer == 6'd1) begin
                        state <= ST_ALIVE;
                        timer <= '0;
                    end else begin
                        timer <= timer - 6'd1;
                    end
                end
                default: begin
                    state <= ST_DEAD;
                end
            endcase
        end
    end
endmodule

module frame_hit_resolver #(
    parameter int NUM_NPC        = 10,
    parameter int NUM_ROCKETS    = 15,
    parameter int START_LIVES    = 3,
    parameter int NPC_POINTS     = 100,
    parameter int EXPLODE_FRAMES = 8,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic                   VGA_CLK,
    input  logic                   Reset,
    input  logic                   frame_clk,
    input  logic                   Ship_Collision,
    input  logic                   Ship_Collision2,
    input  logic [NUM_NPC-1:0]     NPC_Collision,
    input  logic [NUM_ROCKETS-1:0] Rocket_Collision,
    input  logic [NUM_ROCKETS-1:0] Rocket_Collision2,
    output logic [NUM_NPC-1:0]     npc_alive,
    output logic [NUM_NPC-1:0]     npc_exploding,
    output logic [NUM_ROCKETS-1:0] rocket_kill,
    output logic [NUM_ROCKETS-1:0] rocket_kill2,
    output logic [1:0]             ship_state,
    output logic [1:0]             ship_state2,
    output logic [2:0]             lives,
    output logic [2:0]             lives2,
    output logic [15:0]            score,
    output logic [7:0]             wave,
    output logic                   wave_clear,
    output logic                   game_over
);
    localparam logic [1:0] ST_DEAD = 2'd3;

    logic               fc_q;
    logic               tick;
    logic               all_quiet;
    logic [NUM_NPC-1:0] hits;
    logic [19:0]        gain;
    logic [3:0]         boom_cnt [NUM_NPC];

    function automatic logic [19:0] popcount(input logic [NUM_NPC-1:0] v);
        logic [19:0] n;
        n = '0;
        for (int i = 0; i < NUM_NPC; i++) n = n + 20'(v[i]);
        return n;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] cur, input logic [19:0] add);
        logic [19:0] sum;
        sum = {4'd0, cur} + add;
        return (sum > 20'h0FFFF) ? 16'hFFFF : sum[15:0];
    endfunction

    always_comb begin
        tick      = frame_clk & ~fc_q;
        hits      = NPC_Collision & npc_alive;
        gain      = 20'(NPC_POINTS) * popcount(hits);
        all_quiet = (npc_alive == '0);
        for (int i = 0; i < NUM_NPC; i++) begin
            npc_exploding[i] = (boom_cnt[i] != 4'd0);
            if (boom_cnt[i] != 4'd0) all_quiet = 1'b0;
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (Reset) fc_q <= 1'b0;
        else       fc_q <= frame_clk;
    end

    // NPC field, score and wave; all frozen once the game is over.
    always_ff @(posedge VGA_CLK) begin
        if (Reset) begin
            npc_alive   <= '1;
            score       <= '0;
            wave        <= '0;
            wave_clear  <= 1'b0;
            rocket_kill <= '0;
            for (int i = 0; i < NUM_NPC; i++) boom_cnt[i] <= 4'd0;
        end else begin
            wave_clear  <= 1'b0;
            rocket_kill <= Rocket_Collision & {NUM_ROCKETS{tick}};
            if (tick && !game_over) begin
                if (all_quiet) begin
                    npc_alive  <= '1;
                    wave       <= wave + 8'd1;
                    wave_clear <= 1'b1;
                end else begin
                    npc_alive <= npc_alive & ~hits;
                    score     <= sat_add(score, gain);
                    for (int i = 0; i < NUM_NPC; i++) begin
                        if (hits[i])                   boom_cnt[i] <= 4'(EXPLODE_FRAMES);
                        else if (boom_cnt[i] != 4'd0) boom_cnt[i] <= boom_cnt[i] - 4'd1;
                    end
                end
            end
        end
    end

    frame_hit_ship #(
        .START_LIVES   (START_LIVES),
        .EXPLODE_FRAMES(EXPLODE_FRAMES),
        .RESPAWN_FRAMES(RESPAWN_FRAMES)
    ) u_ship1 (
        .VGA_CLK(VGA_CLK),
        .Reset  (Reset),
        .tick   (tick),
        .hit    (Ship_Collision),
        .state  (ship_state),
        .lives  (lives)
    );

`ifdef TWO_PLAYER_EN
    frame_hit_ship #(
        .START_LIVES   (START_LIVES),
        .EXPLODE_FRAMES(EXPLODE_FRAMES),
        .RESPAWN_FRAMES(RESPAWN_FRAMES)
    ) u_ship2 (
        .VGA_CLK(VGA_CLK),
        .Reset  (Reset),
        .tick   (tick),
        .hit    (Ship_Collision2),
        .state  (ship_state2),
        .lives  (lives2)
    );

    always_ff @(posedge VGA_CLK) begin
        if (Reset) rocket_kill2 <= '0;
        else       rocket_kill2 <= Rocket_Collision2 & {NUM_ROCKETS{tick}};
    end

    assign game_over = (ship_state == ST_DEAD) && (ship_state2 == ST_DEAD);
`else
    logic unused_p2;
    assign unused_p2    = ^{Ship_Collision2, Rocket_Collision2};
    assign ship_state2  = ST_DEAD;
    assign lives2       = 3'd0;
    assign rocket_kill2 = '0;
    assign game_over    = (ship_state == ST_DEAD);
`endif
endmodule

// File: tb/tb_frame_hit_resolver.sv
// Directed bench for frame_hit_resolver in its default single-player build.
module tb_frame_hit_resolver;
    logic        VGA_CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic        Ship_Collision = 1'b0;
    logic        Ship_Collision2 = 1'b0;
    logic [9:0]  NPC_Collision = '0;
    logic [14:0] Rocket_Collision = '0;
    logic [14:0] Rocket_Collision2 = '0;
    logic [9:0]  npc_alive, npc_exploding;
    logic [14:0] rocket_kill, rocket_kill2;
    logic [1:0]  ship_state, ship_state2;
    logic [2:0]  lives, lives2;
    logic [15:0] score;
    logic [7:0]  wave;
    logic        wave_clear, game_over;

    int checks = 0;
    int errors = 0;

    frame_hit_resolver dut (
        .VGA_CLK          (VGA_CLK),
        .Reset            (Reset),
        .frame_clk        (frame_clk),
        .Ship_Collision   (Ship_Collision),
        .Ship_Collision2  (Ship_Collision2),
        .NPC_Collision    (NPC_Collision),
        .Rocket_Collision (Rocket_Collision),
        .Rocket_Collision2(Rocket_Collision2),
        .npc_alive        (npc_alive),
        .npc_exploding    (npc_exploding),
        .rocket_kill      (rocket_kill),
        .rocket_kill2     (rocket_kill2),
        .ship_state       (ship_state),
        .ship_state2      (ship_state2),
        .lives            (lives),
        .lives2           (lives2),
        .score            (score),
        .wave             (wave),
        .wave_clear       (wave_clear),
        .game_over        (game_over)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame: strobe high for one cycle with the given flags; returns on the
    // falling edge right after the updating clock edge.
    task automatic frame(input logic s1, input logic s2, input logic [9:0] npc,
                         input logic [14:0] rk, input logic [14:0] rk2);
        @(negedge VGA_CLK);
        Ship_Collision    = s1;
        Ship_Collision2   = s2;
        NPC_Collision     = npc;
        Rocket_Collision  = rk;
        Rocket_Collision2 = rk2;
        frame_clk         = 1'b1;
        @(negedge VGA_CLK);
        frame_clk         = 1'b0;
        Ship_Collision    = 1'b0;
        Ship_Collision2   = 1'b0;
        NPC_Collision     = '0;
        Rocket_Collision  = '0;
        Rocket_Collision2 = '0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) frame(1'b0, 1'b0, 10'h000, 15'h0, 15'h0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_alive"}, 32'(npc_alive), 32'h3FF);
        check({tag, "_expl"}, 32'(npc_exploding), 32'h0);
        check({tag, "_score"}, 32'(score), 32'h0);
        check({tag, "_wave"}, 32'(wave), 32'h0);
        check({tag, "_lives"}, 32'(lives), 32'd3);
        check({tag, "_state"}, 32'(ship_state), 32'd0);
        check({tag, "_gover"}, 32'(game_over), 32'd0);
        check({tag, "_rkill"}, 32'(rocket_kill), 32'h0);
        check({tag, "_wclr"}, 32'(wave_clear), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc_seen;
        repeat (3) @(negedge VGA_CLK);
        Reset = 1'b0;
        @(negedge VGA_CLK);
        check_reset_state("rst");
        check("rst_state2", 32'(ship_state2), 32'd3);
        check("rst_lives2", 32'(lives2), 32'd0);

        // Idle frames leave everything alone.
        wc_seen = 0;
        for (int k = 0; k < 3; k++) begin
            idle(1);
            if (wave_clear) wc_seen++;
        end
        check("idle_wclr", 32'(wc_seen), 32'd0);
        check("idle_alive", 32'(npc_alive), 32'h3FF);
        check("idle_score", 32'(score), 32'd0);
        check("idle_lives", 32'(lives), 32'd3);

        // Single NPC hit plus a rocket retire.
        frame(1'b0, 1'b0, 10'h001, 15'h4001, 15'h0);
        check("hit1_alive", 32'(npc_alive), 32'h3FE);
        check("hit1_score", 32'(score), 32'd100);
        check("hit1_expl", 32'(npc_exploding), 32'h001);
        check("hit1_rkill", 32'(rocket_kill), 32'h4001);
        @(negedge VGA_CLK);
        check("hit1_rkill_off", 32'(rocket_kill), 32'h0);
        idle(7);
        check("expl_7", 32'(npc_exploding), 32'h001);
        idle(1);
        check("expl_8", 32'(npc_exploding), 32'h000);
        frame(1'b0, 1'b0, 10'h001, 15'h0, 15'h0);
        check("rehit_score", 32'(score), 32'd100);
        check("rehit_alive", 32'(npc_alive), 32'h3FE);

        // Three at once.
        frame(1'b0, 1'b0, 10'h070, 15'h0, 15'h0);
        check("hit3_score", 32'(score), 32'd400);
        check("hit3_alive", 32'(npc_alive), 32'h38E);

        // Wipe the rest: six live slots among the ten flagged.
        frame(1'b0, 1'b0, 10'h3FF, 15'h0, 15'h0);
        check("wipe_score", 32'(score), 32'd1000);
        check("wipe_alive", 32'(npc_alive), 32'h000);
        check("wipe_expl", 32'(npc_exploding), 32'h3FE);
        idle(7);
        check("wipe_expl7", 32'(npc_exploding), 32'h38E);
        idle(1);
        check("wipe_expl8", 32'(npc_exploding), 32'h000);
        check("wipe_wave0", 32'(wave), 32'd0);
        check("wipe_wclr0", 32'(wave_clear), 32'd0);
        frame(1'b0, 1'b0, 10'h3FF, 15'h0, 15'h0);
        check("wave_pulse", 32'(wave_clear), 32'd1);
        check("wave_cnt", 32'(wave), 32'd1);
        check("wave_alive", 32'(npc_alive), 32'h3FF);
        check("wave_score", 32'(score), 32'd1000);
        @(negedge VGA_CLK);
        check("wave_pulse_off", 32'(wave_clear), 32'd0);

        // Drive the score toward the ceiling, one full wave per pass.
        for (int w = 0; w < 64; w++) begin
            frame(1'b0, 1'b0, 10'h3FF, 15'h0, 15'h0);
            idle(9);
        end
        check("sat_pre", 32'(score), 32'd65000);
        check("sat_wave", 32'(wave), 32'd65);
        frame(1'b0, 1'b0, 10'h01F, 15'h0, 15'h0);
        check("sat_near", 32'(score), 32'hFFDC);
        frame(1'b0, 1'b0, 10'h020, 15'h0, 15'h0);
        check("sat_hit", 32'(score), 32'hFFFF);
        frame(1'b0, 1'b0, 10'h040, 15'h0, 15'h0);
        check("sat_hold", 32'(score), 32'hFFFF);
        check("sat_alive", 32'(npc_alive), 32'h380);

        // Reset while explosions are running.
        @(negedge VGA_CLK);
        Reset = 1'b1;
        @(negedge VGA_CLK);
        Reset = 1'b0;
        check_reset_state("rst2");

        // Ship hit with a simultaneous NPC hit; ship 2 flags must be ignored.
        frame(1'b1, 1'b1, 10'h001, 15'h0, 15'h7FFF);
        check("ship_state1", 32'(ship_state), 32'd1);
        check("ship_lives1", 32'(lives), 32'd2);
        check("ship_score", 32'(score), 32'd100);
        check("ship2_state", 32'(ship_state2), 32'd3);
        check("ship2_lives", 32'(lives2), 32'd0);
        check("ship2_rkill", 32'(rocket_kill2), 32'h0);
        idle(7);
        check("expl_hold", 32'(ship_state), 32'd1);
        idle(1);
        check("respawn", 32'(ship_state), 32'd2);
        frame(1'b1, 1'b0, 10'h000, 15'h0, 15'h0);
        check("respawn_ign_st", 32'(ship_state), 32'd2);
        check("respawn_ign_lv", 32'(lives), 32'd2);
        idle(58);
        check("respawn_59", 32'(ship_state), 32'd2);
        idle(1);
        check("respawn_60", 32'(ship_state), 32'd0);

        // Second life.
        frame(1'b1, 1'b0, 10'h000, 15'h0, 15'h0);
        check("hit2_lives", 32'(lives), 32'd1);
        idle(8);
        check("hit2_resp", 32'(ship_state), 32'd2);
        idle(60);
        check("hit2_alive", 32'(ship_state), 32'd0);

        // Last life.
        frame(1'b1, 1'b0, 10'h000, 15'h0, 15'h0);
        check("hit3_st", 32'(ship_state), 32'd1);
        check("hit3_lives", 32'(lives), 32'd0);
        idle(7);
        check("hit3_expl", 32'(ship_state), 32'd1);
        check("hit3_go0", 32'(game_over), 32'd0);
        idle(1);
        check("dead_state", 32'(ship_state), 32'd3);
        check("dead_gover", 32'(game_over), 32'd1);

        // Game over freezes the field but rockets still retire.
        frame(1'b1, 1'b0, 10'h002, 15'h0003, 15'h0);
        check("go_score", 32'(score), 32'd100);
        check("go_alive", 32'(npc_alive), 32'h3FE);
        check("go_rkill", 32'(rocket_kill), 32'h0003);
        check("go_state", 32'(ship_state), 32'd3);
        check("go_lives", 32'(lives), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
